// File: rtl/nand_mover_pkg.sv
// Shared types for the NAND page mover: FSM states, transfer op codes and counter sizing.
package nand_mover_pkg;

    typedef enum logic [3:0] {
        IDLE, P_FETCH, P_WAIT, P_LO, P_HI, R_LO, R_WR, R_HI, DONE
    } state_t;

    typedef enum logic {OP_PROG, OP_READ} op_t;

    function automatic int cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/nand_page_mover_strobe_timer.sv
// Loadable down-counter timing the low and high phases of the WE#/RE# strobes.
module strobe_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/nand_page_mover.sv
// Page mover between the page buffer controller port and NAND I/O pins.
// Optional NAND_MOVER_CHECKSUM_EN adds an XOR checksum of every word moved.
module nand_page_mover
    import nand_mover_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PAGE_WORDS = 2048,
    parameter int STROBE_LO  = 2,
    parameter int STROBE_HI  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_prog,
    input  logic                  start_read,
    output logic                  busy,
    output logic                  done,
    output logic                  cntrl_sel,
    output logic                  cntrl_re,
    output logic                  cntrl_we,
    input  logic [DATA_WIDTH-1:0] cntrl_out,
    output logic [DATA_WIDTH-1:0] cntrl_in,
`ifdef NAND_MOVER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] xfer_checksum,
`endif
    output logic [DATA_WIDTH-1:0] nand_io_out,
    output logic                  nand_io_oe,
    input  logic [DATA_WIDTH-1:0] nand_io_in,
    output logic                  nand_we_n,
    output logic                  nand_re_n
);

    localparam int CW   = cnt_width(PAGE_WORDS);
    localparam int TMAX = (STROBE_LO > STROBE_HI) ? STROBE_LO : STROBE_HI;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [CW-1:0] LAST  = CW'(PAGE_WORDS - 1);
    localparam logic [TW-1:0] LO_LD = TW'(STROBE_LO - 1);
    localparam logic [TW-1:0] HI_LD = TW'(STROBE_HI - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] io_out_q, cin_q;
    op_t                   start_op;
    logic                  start_any, tmr_load, tmr_exp;
    logic [TW-1:0]         tmr_val;

    assign start_any = start_prog | start_read;

    strobe_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_exp)
    );

    // Program takes priority when both starts arrive together.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmr_load = 1'b0;
        tmr_val  = LO_LD;
        start_op = start_prog ? OP_PROG : OP_READ;
        case (state_q)
            IDLE: if (start_any) begin
                if (start_op == OP_PROG) begin
                    state_d = P_FETCH;
                end else begin
                    state_d  = R_LO;
                    tmr_load = 1'b1;
                end
            end
            P_FETCH: state_d = P_WAIT;
            P_WAIT: begin
                state_d  = P_LO;
                tmr_load = 1'b1;
            end
            P_LO: if (tmr_exp) begin
                state_d  = P_HI;
                tmr_load = 1'b1;
                tmr_val  = HI_LD;
            end
            P_HI: if (tmr_exp) begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = P_FETCH;
                end
            end
            R_LO: if (tmr_exp) state_d = R_WR;
            R_WR: begin
                state_d  = R_HI;
                tmr_load = 1'b1;
                tmr_val  = HI_LD;
            end
            R_HI: if (tmr_exp) begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    state_d  = R_LO;
                    tmr_load = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            io_out_q <= '0;
            cin_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == P_WAIT)
                io_out_q <= cntrl_out;
            if (state_q == R_LO && tmr_exp)
                cin_q <= nand_io_in;
        end
    end

`ifdef NAND_MOVER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            csum_q <= '0;
        else if (state_q == IDLE && start_any)
            csum_q <= '0;
        else if (state_q == P_WAIT)
            csum_q <= csum_q ^ cntrl_out;
        else if (state_q == R_LO && tmr_exp)
            csum_q <= csum_q ^ nand_io_in;
    end

    assign xfer_checksum = csum_q;
`endif

    // Output enable spans from the first P_WAIT until DONE, including later fetches.
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign cntrl_sel   = busy;
    assign cntrl_re    = (state_q == P_FETCH);
    assign cntrl_we    = (state_q == R_WR);
    assign cntrl_in    = cin_q;
    assign nand_io_out = io_out_q;
    assign nand_io_oe  = (state_q == P_WAIT) || (state_q == P_LO) || (state_q == P_HI) ||
                         (state_q == P_FETCH && cnt_q != '0);
    assign nand_we_n   = (state_q != P_LO);
    assign nand_re_n   = (state_q != R_LO);

endmodule

// File: tb/tb_nand_page_mover.sv
// Directed bench for nand_page_mover with buffer and NAND pin models (PAGE_WORDS=4, LO=2, HI=1).
module tb_nand_page_mover;

    logic        clk = 1'b0;
    logic        rst_n, start_prog, start_read;
    logic        busy, done, cntrl_sel, cntrl_re, cntrl_we;
    logic [15:0] cntrl_out, cntrl_in, nand_io_out, nand_io_in;
    logic        nand_io_oe, nand_we_n, nand_re_n;
`ifdef NAND_MOVER_CHECKSUM_EN
    logic [15:0] xfer_checksum;
`endif

    always #5 clk = ~clk;

    nand_page_mover #(
        .DATA_WIDTH(16), .PAGE_WORDS(4), .STROBE_LO(2), .STROBE_HI(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_prog(start_prog), .start_read(start_read),
        .busy(busy), .done(done), .cntrl_sel(cntrl_sel), .cntrl_re(cntrl_re),
        .cntrl_we(cntrl_we), .cntrl_out(cntrl_out), .cntrl_in(cntrl_in),
`ifdef NAND_MOVER_CHECKSUM_EN
        .xfer_checksum(xfer_checksum),
`endif
        .nand_io_out(nand_io_out), .nand_io_oe(nand_io_oe), .nand_io_in(nand_io_in),
        .nand_we_n(nand_we_n), .nand_re_n(nand_re_n)
    );

    // Models: buffer read port, buffer write log, NAND program log and NAND read source.
    logic [15:0] mem_rd [4];
    logic [15:0] nand_data [4];
    logic [15:0] wr_log [8];
    logic [15:0] nand_log [8];
    int          rd_ptr, wn, pn, ridx, fetch_n, re_low_n;
    logic        clr, we_d, re_d, oe_seen;

    assign nand_io_in = nand_data[ridx[1:0]];

    always @(posedge clk) begin
        we_d <= nand_we_n;
        re_d <= nand_re_n;
        if (!cntrl_sel) rd_ptr <= 0;
        else if (cntrl_re) begin
            cntrl_out <= mem_rd[rd_ptr[1:0]];
            rd_ptr    <= rd_ptr + 1;
        end
        if (clr) begin
            wn <= 0; pn <= 0; ridx <= 0; fetch_n <= 0; re_low_n <= 0; oe_seen <= 1'b0;
        end else begin
            if (cntrl_we && wn < 8) begin
                wr_log[wn] <= cntrl_in;
                wn         <= wn + 1;
            end
            if (nand_we_n && !we_d && pn < 8) begin
                nand_log[pn] <= nand_io_out;
                pn           <= pn + 1;
            end
            if (nand_re_n && !re_d) ridx <= ridx + 1;
            if (!nand_re_n) re_low_n <= re_low_n + 1;
            if (cntrl_re) fetch_n <= fetch_n + 1;
            if (nand_io_oe) oe_seen <= 1'b1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Drives the start pulse in cycle 0 and returns at cycle 1 (#1 after the sampling edge).
    task automatic start_op(input logic p, input logic r);
        start_prog = p; start_read = r; clr = 1'b1;
        @(posedge clk); #1;
        start_prog = 1'b0; start_read = 1'b0; clr = 1'b0;
    endtask

    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (!done && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) $display("FAIL timeout: no done pulse by cycle %0d", k);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    int k;

    initial begin
        rst_n = 1'b0; start_prog = 1'b0; start_read = 1'b0; clr = 1'b1;
        nand_data[0] = 16'h0; nand_data[1] = 16'h0; nand_data[2] = 16'h0; nand_data[3] = 16'h0;
        step(3);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_sel", 32'(cntrl_sel), 32'h0);
        chk("rst_re", 32'(cntrl_re), 32'h0);
        chk("rst_we", 32'(cntrl_we), 32'h0);
        chk("rst_cin", 32'(cntrl_in), 32'h0);
        chk("rst_io", 32'(nand_io_out), 32'h0);
        chk("rst_oe", 32'(nand_io_oe), 32'h0);
        chk("rst_we_n", 32'(nand_we_n), 32'h1);
        chk("rst_re_n", 32'(nand_re_n), 32'h1);
        rst_n = 1'b1; clr = 1'b0;
        step(1);

        // Program one page.
        mem_rd[0] = 16'hA001; mem_rd[1] = 16'hA002; mem_rd[2] = 16'hA003; mem_rd[3] = 16'hA004;
        start_op(1'b1, 1'b0);
        chk("prog_busy", 32'(busy), 32'h1);
        chk("prog_sel", 32'(cntrl_sel), 32'h1);
        step(3);
        chk("prog_oe", 32'(nand_io_oe), 32'h1);
        wait_done(4, k);
        chk("prog_lat", 32'(k), 32'd21);
        chk("prog_busy_done", 32'(busy), 32'h0);
        chk("prog_oe_done", 32'(nand_io_oe), 32'h0);
        chk("prog_n", 32'(pn), 32'd4);
        chk("prog_w0", 32'(nand_log[0]), 32'hA001);
        chk("prog_w1", 32'(nand_log[1]), 32'hA002);
        chk("prog_w2", 32'(nand_log[2]), 32'hA003);
        chk("prog_w3", 32'(nand_log[3]), 32'hA004);
        chk("prog_fetch", 32'(fetch_n), 32'd4);
        chk("prog_no_re", 32'(re_low_n), 32'd0);

        // Read issued in the cycle right after done.
        nand_data[0] = 16'h5A5A; nand_data[1] = 16'hFFFF; nand_data[2] = 16'h0000; nand_data[3] = 16'h1234;
        step(1);
        chk("done_pulse", 32'(done), 32'h0);
        start_op(1'b0, 1'b1);
        chk("b2b_busy", 32'(busy), 32'h1);
        wait_done(1, k);
        chk("read_lat", 32'(k), 32'd17);
        chk("read_n", 32'(wn), 32'd4);
        chk("read_w0", 32'(wr_log[0]), 32'h5A5A);
        chk("read_w1", 32'(wr_log[1]), 32'hFFFF);
        chk("read_w2", 32'(wr_log[2]), 32'h0000);
        chk("read_w3", 32'(wr_log[3]), 32'h1234);
        chk("read_re_low", 32'(re_low_n), 32'd8);
        chk("read_no_oe", 32'(oe_seen), 32'h0);
        step(2);

        // Both starts together, then a stray start_read mid-program.
        mem_rd[0] = 16'hB001; mem_rd[1] = 16'hB002; mem_rd[2] = 16'hB003; mem_rd[3] = 16'hB004;
        start_op(1'b1, 1'b1);
        step(7);
        start_read = 1'b1;
        step(1);
        start_read = 1'b0;
        wait_done(9, k);
        chk("both_lat", 32'(k), 32'd21);
        chk("both_no_re", 32'(re_low_n), 32'd0);
        chk("both_n", 32'(pn), 32'd4);
        chk("both_w3", 32'(nand_log[3]), 32'hB004);
        chk("both_wr", 32'(wn), 32'd0);
        step(2);
        chk("both_idle", 32'(busy), 32'h0);

        // Reset during the second word's low strobe.
        start_op(1'b1, 1'b0);
        step(7);
        chk("mid_we_low", 32'(nand_we_n), 32'h0);
        rst_n = 1'b0;
        step(1);
        chk("mid_we_n", 32'(nand_we_n), 32'h1);
        chk("mid_oe", 32'(nand_io_oe), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step(1);
        mem_rd[0] = 16'hC001; mem_rd[1] = 16'hC002; mem_rd[2] = 16'hC003; mem_rd[3] = 16'hC004;
        start_op(1'b1, 1'b0);
        wait_done(1, k);
        chk("after_rst_lat", 32'(k), 32'd21);
        chk("after_rst_n", 32'(pn), 32'd4);
        chk("after_rst_w0", 32'(nand_log[0]), 32'hC001);
        chk("after_rst_w3", 32'(nand_log[3]), 32'hC004);
        step(2);

`ifdef NAND_MOVER_CHECKSUM_EN
        mem_rd[0] = 16'h00FF; mem_rd[1] = 16'h0F0F; mem_rd[2] = 16'hF000; mem_rd[3] = 16'h0001;
        start_op(1'b1, 1'b0);
        wait_done(1, k);
        chk("csum_done", 32'(xfer_checksum), 32'hFFF1);
        step(2);
        chk("csum_hold", 32'(xfer_checksum), 32'hFFF1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
